// File: rtl/shot_clock_pkg.sv
// Shared types and widths for the shot-clock sequencer.
package shot_clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } sc_state_t;

  localparam int SECS_W = 5;
  localparam int TNTH_W = 4;

endpackage

// File: rtl/sc_tick_edge.sv
// Turns the 10 ms toggle level into a one-cycle event per flip.
module sc_tick_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_toggle,
  output logic tick_ev
);

  logic tick_q;

  // Delay the toggle level by one clock so that a flip shows up as a difference.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_toggle;
    end
  end

  assign tick_ev = tick_toggle ^ tick_q;

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot-clock sequencer: run/pause FSM, 10 ms sub counter, seconds.tenths
// register and the expiry horn.
// Build option: define SHOT_CLOCK_BUZZER_EN to drive the horn for BUZZ_TNTH
// tenths after expiry; otherwise buzzer is tied low.
module shot_clock_ctrl
  import shot_clock_pkg::*;
#(
  parameter int FULL_SECS      = 24,
  parameter int SHORT_SECS     = 14,
  parameter int TICKS_PER_TNTH = 10,
  parameter int BUZZ_TNTH      = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick_toggle,
  input  logic              start_pause,
  input  logic              reload24,
  input  logic              reload14,
  output logic [SECS_W-1:0] secs,
  output logic [TNTH_W-1:0] tenths,
  output logic              running,
  output logic              expired,
  output logic              buzzer
);

  localparam int SUB_W = (TICKS_PER_TNTH > 1) ? $clog2(TICKS_PER_TNTH) : 1;

  sc_state_t         state;
  logic [SUB_W-1:0]  sub;
  logic              tick_ev;
  logic              buzz_active;
  logic              reload_any;
  logic              r14_load;
  logic              sp_act;
  logic              cnt_en;
  logic              sub_wrap;
  logic              tenth_ev;
  logic              expire_now;

  sc_tick_edge u_tick_edge (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick_toggle (tick_toggle),
    .tick_ev     (tick_ev)
  );

  // Remaining < SHORT_SECS.0 is equivalent to whole seconds below SHORT_SECS.
  assign reload_any = reload24 | reload14;
  assign r14_load   = reload14 & (secs < SECS_W'(SHORT_SECS));
  // A start/pause in EXPIRED is ignored, so it must not steal the tick either.
  assign sp_act     = start_pause & (state != EXPIRED);
  assign cnt_en     = (state == RUN) | ((state == EXPIRED) & buzz_active);
  assign sub_wrap   = (sub == SUB_W'(TICKS_PER_TNTH - 1));
  // Reloads and an accepted start/pause take precedence over the tick.
  assign tenth_ev   = cnt_en & tick_ev & sub_wrap & ~reload_any & ~sp_act;
  assign expire_now = tenth_ev & (state == RUN) &
                      (secs == '0) & (tenths == TNTH_W'(1));

  // Sub-tenth counter: advances on ticks while counting, frozen otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub <= '0;
    end else if (reload24 || r14_load) begin
      sub <= '0;
    end else if (reload14 || sp_act) begin
      sub <= sub;
    end else if (cnt_en && tick_ev) begin
      sub <= sub_wrap ? '0 : sub + SUB_W'(1);
    end
  end

  // Control FSM and the remaining-time register, all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      secs    <= SECS_W'(FULL_SECS);
      tenths  <= '0;
      running <= 1'b0;
      expired <= 1'b0;
    end else if (reload_any) begin
      if (reload24) begin
        secs   <= SECS_W'(FULL_SECS);
        tenths <= '0;
      end else if (r14_load) begin
        secs   <= SECS_W'(SHORT_SECS);
        tenths <= '0;
      end
      if (state == EXPIRED) begin
        state   <= PAUSE;
        running <= 1'b0;
        expired <= 1'b0;
      end
    end else if (sp_act) begin
      case (state)
        IDLE, PAUSE: begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: begin
          state   <= PAUSE;
          running <= 1'b0;
        end
        default: state <= state;
      endcase
    end else if (tenth_ev && (state == RUN)) begin
      if (tenths != '0) begin
        tenths <= tenths - TNTH_W'(1);
      end else if (secs != '0) begin
        tenths <= TNTH_W'(9);
        secs   <= secs - SECS_W'(1);
      end
      if (expire_now) begin
        state   <= EXPIRED;
        running <= 1'b0;
        expired <= 1'b1;
      end
    end
  end

`ifdef SHOT_CLOCK_BUZZER_EN
  localparam int BUZZ_W = $clog2(BUZZ_TNTH + 1);

  logic [BUZZ_W-1:0] buzz_cnt;

  // Horn: on at expiry, off after BUZZ_TNTH tenths or on any reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buzzer   <= 1'b0;
      buzz_cnt <= '0;
    end else if (reload_any) begin
      buzzer   <= 1'b0;
      buzz_cnt <= '0;
    end else if (expire_now) begin
      buzzer   <= 1'b1;
      buzz_cnt <= '0;
    end else if (buzzer && tenth_ev) begin
      if (buzz_cnt == BUZZ_W'(BUZZ_TNTH - 1)) begin
        buzzer   <= 1'b0;
        buzz_cnt <= '0;
      end else begin
        buzz_cnt <= buzz_cnt + BUZZ_W'(1);
      end
    end
  end

  assign buzz_active = buzzer;
`else
  assign buzzer      = 1'b0;
  assign buzz_active = 1'b0;
`endif

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Directed bench for shot_clock_ctrl with a scoreboard queue and negedge monitor.
module tb_shot_clock_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_toggle = 1'b0;
  logic       start_pause = 1'b0;
  logic       reload24 = 1'b0;
  logic       reload14 = 1'b0;
  logic [4:0] secs;
  logic [3:0] tenths;
  logic       running;
  logic       expired;
  logic       buzzer;

`ifdef SHOT_CLOCK_BUZZER_EN
  localparam bit BZ = 1'b1;
`else
  localparam bit BZ = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [4:0] s;
    logic [3:0] t;
    logic       r;
    logic       e;
    logic       b;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shot_clock_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick_toggle (tick_toggle),
    .start_pause (start_pause),
    .reload24    (reload24),
    .reload14    (reload14),
    .secs        (secs),
    .tenths      (tenths),
    .running     (running),
    .expired     (expired),
    .buzzer      (buzzer)
  );

  // Monitor: compare every queued expectation against the outputs mid-cycle.
  always @(negedge clk) begin
    exp_t x;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      checks++;
      if ({secs, tenths, running, expired, buzzer} !== {x.s, x.t, x.r, x.e, x.b}) begin
        errors++;
        $display("FAIL %s: got %0d.%0d run=%b exp=%b buz=%b, want %0d.%0d run=%b exp=%b buz=%b",
                 x.name, secs, tenths, running, expired, buzzer, x.s, x.t, x.r, x.e, x.b);
      end
    end
  end

  task automatic expect_out(input string n, input int s, input int t,
                            input bit r, input bit e, input bit b);
    exp_t x;
    x.name = n;
    x.s = 5'(s);
    x.t = 4'(t);
    x.r = r;
    x.e = e;
    x.b = b;
    sb_q.push_back(x);
  endtask

  task automatic pulse(input bit sp, input bit r24, input bit r14, input bit flip);
    start_pause = sp;
    reload24    = r24;
    reload14    = r14;
    if (flip) tick_toggle = ~tick_toggle;
    @(posedge clk);
    #1;
    start_pause = 1'b0;
    reload24    = 1'b0;
    reload14    = 1'b0;
  endtask

  task automatic flips(input int n);
    for (int i = 0; i < n; i++) begin
      tick_toggle = ~tick_toggle;
      @(posedge clk);
      #1;
    end
  endtask

  // Watchdog bounds the whole run.
  initial begin
    repeat (60000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: got cycle budget exhausted, want run complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset_hold", 24, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out("reset_release", 24, 0, 0, 0, 0);
    flips(3);
    expect_out("idle_ignores_ticks", 24, 0, 0, 0, 0);

    // Countdown to expiry and horn
    pulse(1, 0, 0, 0);
    expect_out("start", 24, 0, 1, 0, 0);
    flips(10);
    expect_out("first_tenth", 23, 9, 1, 0, 0);
    flips(2389);
    expect_out("at_0.1", 0, 1, 1, 0, 0);
    flips(1);
    expect_out("expiry", 0, 0, 0, 1, BZ);
    flips(199);
    expect_out("buzz_199_flips", 0, 0, 0, 1, BZ);
    flips(1);
    expect_out("buzz_done", 0, 0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    expect_out("expired_sp_ignored", 0, 0, 0, 1, 0);
    pulse(0, 0, 1, 0);
    expect_out("expired_reload14", 14, 0, 0, 0, 0);
    flips(10);
    expect_out("pause_holds", 14, 0, 0, 0, 0);

    // Pause keeps sub
    pulse(1, 0, 0, 0);
    expect_out("resume", 14, 0, 1, 0, 0);
    flips(170);
    expect_out("at_12.3", 12, 3, 1, 0, 0);
    flips(5);
    pulse(1, 0, 0, 0);
    expect_out("pause_12.3", 12, 3, 0, 0, 0);
    flips(50);
    expect_out("pause_50_flips", 12, 3, 0, 0, 0);
    pulse(1, 0, 0, 0);
    flips(4);
    expect_out("resume_sub_kept_a", 12, 3, 1, 0, 0);
    flips(1);
    expect_out("resume_sub_kept_b", 12, 2, 1, 0, 0);

    // Reload behaviour
    pulse(0, 1, 0, 0);
    expect_out("reload24_run", 24, 0, 1, 0, 0);
    flips(550);
    expect_out("at_18.5", 18, 5, 1, 0, 0);
    pulse(0, 0, 1, 0);
    expect_out("r14_above", 18, 5, 1, 0, 0);
    flips(930);
    expect_out("at_9.2", 9, 2, 1, 0, 0);
    pulse(0, 0, 1, 0);
    expect_out("r14_below", 14, 0, 1, 0, 0);
    pulse(0, 1, 1, 0);
    expect_out("r24_r14_both", 24, 0, 1, 0, 0);

    // Priority against tenth_ev and start_pause
    flips(1900);
    expect_out("at_5.0", 5, 0, 1, 0, 0);
    flips(9);
    pulse(0, 1, 0, 1);
    expect_out("r24_with_tenth", 24, 0, 1, 0, 0);
    flips(9);
    expect_out("sub_cleared", 24, 0, 1, 0, 0);
    flips(1);
    expect_out("after_clear", 23, 9, 1, 0, 0);
    flips(2090);
    expect_out("at_3.0", 3, 0, 1, 0, 0);
    pulse(1, 0, 1, 0);
    expect_out("sp_r14_both", 14, 0, 1, 0, 0);

    // Reload during horn
    flips(1400);
    expect_out("expiry2", 0, 0, 0, 1, BZ);
    flips(50);
    expect_out("buzzing", 0, 0, 0, 1, BZ);
    pulse(0, 1, 0, 0);
    expect_out("r24_in_buzz", 24, 0, 0, 0, 0);
    flips(20);
    expect_out("pause_after_buzz", 24, 0, 0, 0, 0);

    // Asynchronous reset mid-run
    pulse(1, 0, 0, 0);
    flips(1650);
    expect_out("at_7.5", 7, 5, 1, 0, 0);
    flips(10);
    #1;
    reset_n = 1'b0;
    #1;
    expect_out("async_reset", 24, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    flips(1);
    expect_out("post_reset_idle", 24, 0, 0, 0, 0);
    flips(9);
    expect_out("post_reset_idle_b", 24, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
